// File: rtl/aes_pkg.sv
// Shared types, key-length tables, GF(2^8) helpers and the AES S-box
// used by the iterative key-expansion block.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  // One-hot encoding so a corrupted register is detectable.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GEN   = 3'b010,
    ST_DRAIN = 3'b100
  } state_e;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0x00 lives in the top byte; lookup index is {~x, 3'b000}.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign dout[gi*8 +: 8] = SBOX_FLAT[{~din[gi*8 +: 8], 3'b000} +: 8];
  end

endmodule

// File: rtl/key_exp_multi.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle,
// packed into 128-bit round keys on a valid/ready stream.
module key_exp_multi
  import aes_pkg::*;
#(
  parameter int EN_192 = 1,
  parameter int EN_256 = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic         abort,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         key_len_err,
  output logic         o_state_error
);

  state_e       state, state_next;
  logic         state_err;

  logic [255:0] key_reg;
  logic [3:0]   nk_reg;
  logic [3:0]   nr_reg;
  logic [5:0]   word_idx;
  logic [2:0]   mod_cnt;
  logic [7:0]   rcon;
  logic [31:0]  window    [0:7];
  logic [31:0]  asm_words [0:3];
  logic [31:0]  key_words [0:7];

  logic         len_legal;
  logic         start_ok;
  logic         len_err_now;
  logic         accept;
  logic         stall;
  logic         gen_fire;
  logic         load_out;
  logic         last_word;
  logic         in_key_phase;
  logic         rot_step;
  logic         sub_step;
  logic [3:0]   back_idx;
  logic [31:0]  prev_word;
  logic [31:0]  older_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp_word;
  logic [31:0]  word_new;

  for (genvar gi = 0; gi < 8; gi++) begin : g_key_words
    assign key_words[gi] = key_reg[255 - 32*gi -: 32];
  end

  always_comb begin
    len_legal = 1'b0;
    case (key_len)
      2'b00:   len_legal = 1'b1;
      2'b01:   len_legal = (EN_192 != 0);
      2'b10:   len_legal = (EN_256 != 0);
      default: len_legal = 1'b0;
    endcase
  end

  assign start_ok    = (state == ST_IDLE) && start && !abort && len_legal;
  assign len_err_now = (state == ST_IDLE) && start && !abort && !len_legal;
  assign accept      = rk_valid && rk_ready;

  // Only the word that completes a round key needs the output register.
  assign stall     = (word_idx[1:0] == 2'b11) && rk_valid && !rk_ready;
  assign gen_fire  = (state == ST_GEN) && !abort && !stall;
  assign load_out  = gen_fire && (word_idx[1:0] == 2'b11);
  assign last_word = (word_idx == {nr_reg, 2'b11});

  assign in_key_phase = (word_idx < {2'b00, nk_reg});
  assign back_idx     = 4'd8 - nk_reg;
  assign prev_word    = window[7];
  assign older_word   = window[back_idx[2:0]];
  assign rot_step     = (mod_cnt == 3'd0);
  assign sub_step     = (nk_reg == 4'd8) && (mod_cnt == 3'd4);
  assign sub_in       = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp_word = prev_word;
    if (rot_step)
      temp_word = sub_out ^ {rcon, 24'h0};
    else if (sub_step)
      temp_word = sub_out;
    word_new = in_key_phase ? key_words[word_idx[2:0]] : (older_word ^ temp_word);
  end

  always_comb begin
    state_next = state;
    state_err  = 1'b0;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_GEN;
      ST_GEN: begin
        if (abort)                      state_next = ST_IDLE;
        else if (gen_fire && last_word) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)       state_next = ST_IDLE;
        else if (accept) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        state_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      o_state_error <= 1'b0;
      key_len_err   <= 1'b0;
    end else begin
      state         <= state_next;
      o_state_error <= state_err;
      key_len_err   <= len_err_now;
    end
  end

  // Job context and schedule counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_reg  <= '0;
      nk_reg   <= 4'd4;
      nr_reg   <= 4'd10;
      word_idx <= '0;
      mod_cnt  <= '0;
      rcon     <= 8'h01;
    end else if (start_ok) begin
      key_reg  <= key;
      nk_reg   <= nk_of(key_len_e'(key_len));
      nr_reg   <= nr_of(key_len_e'(key_len));
      word_idx <= '0;
      mod_cnt  <= '0;
      rcon     <= 8'h01;
    end else if (gen_fire) begin
      word_idx <= word_idx + 6'd1;
      mod_cnt  <= ({1'b0, mod_cnt} == nk_reg - 4'd1) ? 3'd0 : mod_cnt + 3'd1;
      if (!in_key_phase && rot_step)
        rcon <= xtime(rcon);
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_window
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        window[gi] <= '0;
      else if (gen_fire)
        window[gi] <= (gi == 7) ? word_new : window[(gi + 1) % 8];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_asm
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        asm_words[gi] <= '0;
      else if (gen_fire)
        asm_words[gi] <= (gi == 3) ? word_new : asm_words[(gi + 1) % 4];
    end
  end

  // Output register: reload and acceptance may coincide without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      rk_last  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (abort || state_err) begin
        rk_valid <= 1'b0;
      end else if (load_out) begin
        rk_valid <= 1'b1;
        rk_data  <= {asm_words[1], asm_words[2], asm_words[3], word_new};
        rk_index <= word_idx[5:2];
        rk_last  <= last_word;
      end else if (accept) begin
        rk_valid <= 1'b0;
      end

      if (abort || state_err)
        busy <= 1'b0;
      else if (start_ok)
        busy <= 1'b1;
      else if ((state == ST_DRAIN) && accept)
        busy <= 1'b0;
    end
  end

endmodule
